// File: rtl/adder.sv
// Registered three-operand unsigned adder: a carry-save layer reduces a, b, c
// to sum/carry vectors, a ripple-carry chain resolves them, result lands in flops.

// Full-adder cell shared by the carry-save layer and the ripple chain.
module adder_fa (
  input  logic x,
  input  logic y,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = x ^ y ^ ci;
  assign co = (x & y) | (ci & (x | y));
endmodule

module adder #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             out_valid
);

  // Valid semantics: no backpressure. Every edge with in_valid=1 accepts a,b,c
  // and the result appears with out_valid=1 exactly one edge later; an edge
  // with in_valid=0 drops out_valid and leaves s/cout untouched.

  logic [WIDTH:0]   ps_ext;
  logic [WIDTH:0]   pc;
  logic [WIDTH+1:0] result;

  assign ps_ext[WIDTH] = 1'b0;
  assign pc[0]         = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_csa
    adder_fa u_fa (
      .x  (a[i]),
      .y  (b[i]),
      .ci (c[i]),
      .s  (ps_ext[i]),
      .co (pc[i+1])
    );
  end

  // Each stage owns its carry so the chain is a sequence of distinct nets.
  for (genvar i = 0; i <= WIDTH; i++) begin : g_rca
    logic ci;
    logic co;
    logic sum;
    if (i == 0) begin : g_first
      assign ci = 1'b0;
    end else begin : g_next
      assign ci = g_rca[i-1].co;
    end
    adder_fa u_fa (
      .x  (ps_ext[i]),
      .y  (pc[i]),
      .ci (ci),
      .s  (sum),
      .co (co)
    );
    assign result[i] = sum;
  end

  assign result[WIDTH+1] = g_rca[WIDTH].co;

  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q;
  logic             out_valid_d, out_valid_q;

  // The select is always known, so X operands during idle cycles never reach the flops.
  always_comb begin
    s_d         = s_q;
    cout_d      = cout_q;
    out_valid_d = in_valid;
    if (in_valid) begin
      s_d    = result[WIDTH-1:0];
      cout_d = |result[WIDTH+1:WIDTH];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q         <= '0;
      cout_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      s_q         <= s_d;
      cout_q      <= cout_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign s         = s_q;
  assign cout      = cout_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_adder.sv
// Directed and randomized bench for adder: reference results come from plain
// integer arithmetic on a+b+c, held across idle cycles.
module tb_adder;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [W-1:0] a, b, c;
  logic [W-1:0] s;
  logic         cout;
  logic         out_valid;

  int checks   = 0;
  int failures = 0;

  logic [W:0] exp_q[$];
  logic [W-1:0] exp_s;
  logic         exp_cout;

  adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .a         (a),
    .b         (b),
    .c         (c),
    .s         (s),
    .cout      (cout),
    .out_valid (out_valid)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks
  task automatic drive(input logic v, input logic [W-1:0] ia, input logic [W-1:0] ib,
                       input logic [W-1:0] ic);
    in_valid = v;
    a = ia;
    b = ib;
    c = ic;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model: unsigned sum, wrap to W bits, overflow if sum >= 2^W.
  function automatic logic [W:0] model(input logic [W-1:0] ia, input logic [W-1:0] ib,
                                       input logic [W-1:0] ic);
    int unsigned sum;
    int unsigned lim;
    logic [W-1:0] lo;
    sum = int'(ia) + int'(ib) + int'(ic);
    lim = 1 << W;
    lo  = W'(sum % lim);
    return {(sum >= lim), lo};
  endfunction

  // Scoreboard: push on accepted operands, pop on the next output cycle.
  task automatic send_and_check(input string tag, input logic v, input logic [W-1:0] ia,
                                input logic [W-1:0] ib, input logic [W-1:0] ic);
    logic [W:0] e;
    drive(v, ia, ib, ic);
    if (v) exp_q.push_back(model(ia, ib, ic));
    step();
    chk({tag, "_vld"}, {31'd0, out_valid}, {31'd0, v});
    if (v) begin
      e = exp_q.pop_front();
      exp_s    = e[W-1:0];
      exp_cout = e[W];
    end
    chk({tag, "_s"}, {{(32-W){1'b0}}, s}, {{(32-W){1'b0}}, exp_s});
    chk({tag, "_cout"}, {31'd0, cout}, {31'd0, exp_cout});
  endtask

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, '0, '0);
    exp_s    = '0;
    exp_cout = 1'b0;
    #2;
    chk("rst_s", {{(32-W){1'b0}}, s}, 32'd0);
    chk("rst_cout", {31'd0, cout}, 32'd0);
    chk("rst_vld", {31'd0, out_valid}, 32'd0);
    #10;
    rst_n = 1'b1;
    step();

    // 7+8+0 = 15, then idle keeps s
    drive(1'b1, 4'd7, 4'd8, 4'd0);
    step();
    chk("t1_s", {{(32-W){1'b0}}, s}, 32'd15);
    chk("t1_cout", {31'd0, cout}, 32'd0);
    chk("t1_vld", {31'd0, out_valid}, 32'd1);
    drive(1'b0, 4'd3, 4'd3, 4'd3);
    step();
    chk("t1_idle_vld", {31'd0, out_valid}, 32'd0);
    chk("t1_idle_s", {{(32-W){1'b0}}, s}, 32'd15);

    // exact wrap at 2^W
    drive(1'b1, 4'd8, 4'd8, 4'd0);
    step();
    chk("wrap_s", {{(32-W){1'b0}}, s}, 32'd0);
    chk("wrap_cout", {31'd0, cout}, 32'd1);

    // max sum 45: overflow flag is 1, not 2
    drive(1'b1, 4'd15, 4'd15, 4'd15);
    step();
    chk("max_s", {{(32-W){1'b0}}, s}, 32'd13);
    chk("max_cout", {31'd0, cout}, 32'd1);

    // back-to-back
    drive(1'b1, 4'd1, 4'd2, 4'd3);
    step();
    chk("b2b0_s", {{(32-W){1'b0}}, s}, 32'd6);
    chk("b2b0_cout", {31'd0, cout}, 32'd0);
    chk("b2b0_vld", {31'd0, out_valid}, 32'd1);
    drive(1'b1, 4'd4, 4'd4, 4'd4);
    step();
    chk("b2b1_s", {{(32-W){1'b0}}, s}, 32'd12);
    chk("b2b1_cout", {31'd0, cout}, 32'd0);
    chk("b2b1_vld", {31'd0, out_valid}, 32'd1);
    drive(1'b1, 4'd0, 4'd0, 4'd0);
    step();
    chk("b2b2_s", {{(32-W){1'b0}}, s}, 32'd0);
    chk("b2b2_cout", {31'd0, cout}, 32'd0);
    chk("b2b2_vld", {31'd0, out_valid}, 32'd1);

    // X operands while idle must not disturb held outputs
    drive(1'b1, 4'd9, 4'd2, 4'd1);
    step();
    chk("xpre_s", {{(32-W){1'b0}}, s}, 32'd12);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b0;
      a = 'x;
      b = (i % 2 == 0) ? 'x : W'($urandom);
      c = 'x;
      step();
      chk("xidle_s", {{(32-W){1'b0}}, s}, 32'd12);
      chk("xidle_cout", {31'd0, cout}, 32'd0);
      chk("xidle_vld", {31'd0, out_valid}, 32'd0);
    end

    // asynchronous reset between edges
    drive(1'b1, 4'd9, 4'd9, 4'd9);
    step();
    chk("pre_rst_s", {{(32-W){1'b0}}, s}, 32'd11);
    chk("pre_rst_cout", {31'd0, cout}, 32'd1);
    drive(1'b0, '0, '0, '0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_s", {{(32-W){1'b0}}, s}, 32'd0);
    chk("arst_cout", {31'd0, cout}, 32'd0);
    chk("arst_vld", {31'd0, out_valid}, 32'd0);
    #10;
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("post_rst_s", {{(32-W){1'b0}}, s}, 32'd0);
      chk("post_rst_cout", {31'd0, cout}, 32'd0);
      chk("post_rst_vld", {31'd0, out_valid}, 32'd0);
    end

    // randomized traffic against the reference model
    exp_s    = '0;
    exp_cout = 1'b0;
    for (int i = 0; i < 200; i++) begin
      send_and_check("rnd", ($urandom_range(0, 3) != 0),
                     W'($urandom), W'($urandom), W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL timeout observed=running expected=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
